// File: rtl/nco_mc.sv
// nco_mc: round-robin multi-channel NCO with a two-stage sine/cosine table read.
// Define NCO_MC_COS_EN to build the cosine read path; otherwise cos_out is 0.
module nco_mc #(
    parameter int    PHASE_WIDTH = 32,
    parameter int    DATA_WIDTH  = 16,
    parameter int    NUM_CH      = 4,
    parameter int    LUT_ADDR_W  = 10,
    parameter string SINE_FILE   = "sine.hex"
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    input  logic [$clog2(NUM_CH)-1:0]     cfg_ch,
    input  logic [1:0]                    cfg_sel,
    input  logic [PHASE_WIDTH-1:0]        cfg_data,
    input  logic                          run,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(NUM_CH)-1:0]     out_ch,
    output logic signed [DATA_WIDTH-1:0]  sine_out,
    output logic signed [DATA_WIDTH-1:0]  cos_out
);

    localparam int  CW    = $clog2(NUM_CH);
    localparam int  DEPTH = 1 << LUT_ADDR_W;
    localparam int  SHIFT = PHASE_WIDTH - LUT_ADDR_W;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = real'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);

    // Table contents match the SINE_FILE image; built at elaboration.
    function automatic logic signed [DATA_WIDTH-1:0] f_sin(input int k);
        real a;
        real s;
        a = 2.0 * PI * real'(k) / real'(DEPTH);
        s = AMP * $sin(a);
        if (s >= 0.0)
            f_sin = DATA_WIDTH'($rtoi(s + 0.5));
        else
            f_sin = DATA_WIDTH'($rtoi(s - 0.5));
    endfunction

    logic signed [DATA_WIDTH-1:0] w_rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign w_rom[k] = f_sin(k);
    end

    logic [PHASE_WIDTH-1:0]       r_inc [NUM_CH];
    logic [PHASE_WIDTH-1:0]       r_off [NUM_CH];
    logic [PHASE_WIDTH-1:0]       r_acc [NUM_CH];
    logic [CW-1:0]                r_ptr;
    logic                         r_v1;
    logic [CW-1:0]                r_ch1;
    logic [LUT_ADDR_W-1:0]        r_addr1;
    logic                         r_v2;
    logic [CW-1:0]                r_ch2;
    logic signed [DATA_WIDTH-1:0] r_sin2;

    logic                         w_adv;
    logic                         w_enter;
    logic [PHASE_WIDTH-1:0]       w_phase;
    logic [LUT_ADDR_W-1:0]        w_addr;

    // A held output freezes the whole pipe, including entry.
    assign w_adv   = ~r_v2 | out_ready;
    assign w_enter = run & w_adv;
    assign w_phase = r_acc[r_ptr] + r_off[r_ptr];
    assign w_addr  = LUT_ADDR_W'(w_phase >> SHIFT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_inc[c] <= '0;
                r_off[c] <= '0;
                r_acc[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg_valid && cfg_ch == CW'(c) && cfg_sel == 2'd0)
                    r_inc[c] <= cfg_data;
                if (cfg_valid && cfg_ch == CW'(c) && cfg_sel == 2'd1)
                    r_off[c] <= cfg_data;
                // Clear beats the entry update; the entering sample saw the old acc.
                if (cfg_valid && cfg_ch == CW'(c) && cfg_sel == 2'd2)
                    r_acc[c] <= '0;
                else if (w_enter && r_ptr == CW'(c))
                    r_acc[c] <= r_acc[c] + r_inc[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_v1    <= 1'b0;
            r_ch1   <= '0;
            r_addr1 <= '0;
            r_v2    <= 1'b0;
            r_ch2   <= '0;
            r_sin2  <= '0;
        end else if (w_adv) begin
            r_v1 <= w_enter;
            r_v2 <= r_v1;
            if (w_enter) begin
                r_ptr   <= r_ptr + 1'b1;
                r_ch1   <= r_ptr;
                r_addr1 <= w_addr;
            end
            if (r_v1) begin
                r_ch2  <= r_ch1;
                r_sin2 <= w_rom[r_addr1];
            end
        end
    end

`ifdef NCO_MC_COS_EN
    localparam logic [LUT_ADDR_W-1:0] QTR = LUT_ADDR_W'(DEPTH / 4);

    logic signed [DATA_WIDTH-1:0] r_cos2;
    logic [LUT_ADDR_W-1:0]        w_caddr;

    assign w_caddr = r_addr1 + QTR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cos2 <= '0;
        else if (w_adv && r_v1)
            r_cos2 <= w_rom[w_caddr];
    end

    assign cos_out = r_cos2;
`else
    assign cos_out = '0;
`endif

    assign out_valid = r_v2;
    assign out_ch    = r_ch2;
    assign sine_out  = r_sin2;

endmodule

// File: tb/tb_nco_mc.sv
// tb_nco_mc: directed self-checking bench for nco_mc at default parameters.
// Expected samples are hand-computed table entries for a 1024-entry, 16-bit table.
module tb_nco_mc;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic [1:0]         cfg_ch;
    logic [1:0]         cfg_sel;
    logic [31:0]        cfg_data;
    logic               run;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_ch;
    logic signed [15:0] sine_out;
    logic signed [15:0] cos_out;

    int n_asrt = 0;
    int n_fail = 0;

`ifdef NCO_MC_COS_EN
    localparam int CFULL = 32767;
`else
    localparam int CFULL = 0;
`endif

    int s0[4] = '{0, 32767, 0, -32767};
    int t2[4] = '{0, 0, -201, -201};
    int c5[4] = '{23170, 23170, -23170, 23170};

    nco_mc dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .run       (run),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .sine_out  (sine_out),
        .cos_out   (cos_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ech, input int esin);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_ch"}, out_ch, ech);
        chk({tag, "_sine"}, sine_out, esin);
    endtask

    task automatic step(input string tag, input int ech, input int esin);
        @(posedge clk);
        #1;
        chk_out(tag, ech, esin);
    endtask

    task automatic wcfg(input logic [1:0] ch, input logic [1:0] sel,
                        input logic [31:0] d);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_sel   = sel;
        cfg_data  = d;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        run       = 1'b0;
        out_ready = 1'b1;
        cfg_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_sel   = '0;
        cfg_data  = '0;
        run       = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_sine", sine_out, 0);
        chk("rst_cos", cos_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Quarter-turn step on ch0, round-robin tags
        wcfg(2'd0, 2'd0, 32'h4000_0000);
        run = 1'b1;
        @(posedge clk);
        #1;
        chk("lat_first", out_valid, 0);
        for (int n = 0; n < 16; n++)
            step("rr", n % 4, (n % 4 == 0) ? s0[(n / 4) % 4] : 0);
        run = 1'b0;
        step("drain", 0, 0);
        @(posedge clk);
        #1;
        chk("drain_idle", out_valid, 0);
        run = 1'b1;
        @(posedge clk);
        #1;
        chk("resume_lat", out_valid, 0);
        step("resume1", 1, 0);
        step("resume2", 2, 0);
        step("resume3", 3, 0);
        step("resume0", 0, 32767);

        // Backpressure freeze for 5 cycles
        do_reset();
        wcfg(2'd0, 2'd0, 32'h4000_0000);
        run = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 5; n++)
            step("pre_stall", n % 4, (n % 4 == 0) ? s0[(n / 4) % 4] : 0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            step("stall", 0, 32767);
        out_ready = 1'b1;
        for (int n = 5; n < 13; n++)
            step("post_stall", n % 4, (n % 4 == 0) ? s0[(n / 4) % 4] : 0);

        // Quarter-turn offset on ch1, cosine path
        do_reset();
        wcfg(2'd1, 2'd1, 32'h4000_0000);
        run = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 8; n++) begin
            step("off1", n % 4, (n % 4 == 1) ? 32767 : 0);
            chk("off1_cos", cos_out, (n % 4 == 1) ? 0 : CFULL);
        end

        // Decrementing phase on ch2 wraps through zero
        do_reset();
        wcfg(2'd2, 2'd0, 32'hFFFF_FFFF);
        wcfg(2'd2, 2'd1, 32'h0000_0001);
        run = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 16; n++)
            step("wrap2", n % 4, (n % 4 == 2) ? t2[n / 4] : 0);

        // Clear of ch0 coinciding with its third entry
        do_reset();
        wcfg(2'd0, 2'd0, 32'h4000_0000);
        wcfg(2'd0, 2'd1, 32'h2000_0000);
        run = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            if (e == 9) begin
                cfg_valid = 1'b1;
                cfg_ch    = 2'd0;
                cfg_sel   = 2'd2;
            end
            @(posedge clk);
            #1;
            cfg_valid = 1'b0;
            if (e >= 2)
                chk_out("clr0", (e - 2) % 4,
                        ((e - 2) % 4 == 0) ? c5[(e - 2) / 4] : 0);
        end

        // Asynchronous reset while a sample is on the output
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ch", out_ch, 0);
        chk("arst_sine", sine_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_lat", out_valid, 0);
        step("rel_first", 0, 0);
        step("rel_second", 1, 0);

        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_mc.md
NCO_MC -- requirements
Module: nco_mc

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 32, meaning phase accumulator width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning signed sample width.
REQ-003 SHALL have parameter NUM_CH, default 4, meaning the number of independent channels (power of 2, minimum 2).
REQ-004 SHALL have parameter LUT_ADDR_W, default 10, meaning the sine table address width (LUT_ADDR_W <= PHASE_WIDTH).
REQ-005 SHALL have parameter SINE_FILE, default "sine.hex", meaning the hex table file with 2^LUT_ADDR_W entries.
REQ-006 SHALL have port clk, input, width 1: the single clock.
REQ-007 SHALL have port rst, input, width 1: asynchronous active-low reset.
REQ-008 SHALL have port cfg_valid, input, width 1: config write strobe, always accepted.
REQ-009 SHALL have port cfg_ch, input, width $clog2(NUM_CH): target channel.
REQ-010 SHALL have port cfg_sel, input, width 2: 0 = phase_inc, 1 = phase_offset, 2 = accumulator clear, 3 = ignored.
REQ-011 SHALL have port cfg_data, input, width PHASE_WIDTH: write data.
REQ-012 SHALL have port run, input, width 1: enable sample generation.
REQ-013 SHALL have port out_valid, output, width 1: sample valid.
REQ-014 SHALL have port out_ready, input, width 1: downstream accept.
REQ-015 SHALL have port out_ch, output, width $clog2(NUM_CH): channel tag of the sample.
REQ-016 SHALL have port sine_out, output, width DATA_WIDTH, signed.
REQ-017 SHALL have port cos_out, output, width DATA_WIDTH, signed.

Function
REQ-018 SHALL hold per-channel registers inc[c], off[c] and acc[c], each PHASE_WIDTH bits wide.
REQ-019 SHALL issue channels round-robin 0,1,...,NUM_CH-1,0, advancing the issue pointer only when a sample enters the pipeline.
REQ-020 SHALL let a sample enter the pipeline when run=1 and stage 1 is empty or advancing.
REQ-021 SHALL, on entry for channel c: form phase p = acc[c] + off[c] (mod 2^PHASE_WIDTH), then update acc[c] to acc[c] + inc[c] (mod 2^PHASE_WIDTH).
REQ-022 SHALL set the table address to the top LUT_ADDR_W bits of p, and the cosine address to that address + 2^(LUT_ADDR_W-2), wrapping.
REQ-023 SHALL have table entry k = round((2^(DATA_WIDTH-1)-1)*sin(2*pi*k/2^LUT_ADDR_W)), loaded from SINE_FILE.
REQ-024 SHALL use a two-stage pipeline: stage 1 = phase/address register, stage 2 = ROM read into an output register; the first out_valid occurs 2 cycles after the first entry.
REQ-025 SHALL stall all stages while out_valid=1 and out_ready=0, holding sine_out, cos_out, out_ch and out_valid stable, with no accumulator advance.
REQ-026 SHALL sustain one sample per cycle when run=1 and out_ready=1.
REQ-027 SHALL, when run drops, let in-flight samples drain and not alter acc; generation resumes at the next channel in the pointer.
REQ-028 SHALL make a config write to inc/off take effect at the next entry of that channel.
REQ-029 SHALL, on a clear (sel=2) in the same cycle as that channel's entry, let the clear win: acc[c]=0 and the entering sample uses the pre-clear acc.
REQ-030 SHALL not alter samples already in flight on a config write.

Reset
REQ-031 SHALL, on rst low, asynchronously clear inc, off, acc, the issue pointer, pipeline valids, out_valid, out_ch, sine_out and cos_out to 0.
REQ-032 SHALL discard in-flight samples on reset mid-operation; after release, generation restarts at channel 0.

Configuration
REQ-033 SHALL, with macro NCO_MC_COS_EN defined, generate the cosine read path and drive cos_out per REQ-022.
REQ-034 SHALL, without NCO_MC_COS_EN, omit the cosine path entirely and tie cos_out to 0; all other behaviour is identical.

Verification
REQ-035 SHALL cover: reset, inc[0]=2^30, others 0, run=1, out_ready=1 -> ch0 sine sequence 0, 32767, 0, -32767 (default params) on every 4th output, out_ch cycling 0,1,2,3.
REQ-036 SHALL cover: off[1]=2^30, inc[1]=0, NCO_MC_COS_EN defined -> ch1 sine_out=32767, cos_out=0 on every ch1 sample.
REQ-037 SHALL cover: out_ready held 0 for 5 cycles mid-stream -> outputs frozen, no channel or sample skipped or duplicated after release.
REQ-038 SHALL cover: inc[2]=0xFFFFFFFF -> acc[2] wraps, ch2 phase decrements by 1 per issue, no overflow artifact.
REQ-039 SHALL cover: clear of ch0 in the same cycle as ch0 entry -> that sample uses the old phase; the next ch0 sample uses phase off[0].
REQ-040 SHALL cover: rst asserted while out_valid=1 -> out_valid=0 immediately; after release, first out_ch=0 with sine_out=0.
